stage_wb: RTL and testbench

Write-back stage of the five-stage LoongArch pipeline; consumes the instruction handed off by the memory stage and is the single commit point of the core. Registers the memory-stage payload, extracts and sign/zero-extends load data, and drives the register-file write port. Performs CSR and TLB-maintenance commits. Raises exception, ertn and refresh redirects (`br_from_WB`) that flush all younger stages.

---
 rtl/stage_wb_pkg.sv | 25 ++
 rtl/stage_wb_load_extend.sv | 31 +++
 rtl/stage_wb.sv | 183 ++++++++++++++++++
 tb/tb_stage_wb.sv | 434 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stage_wb_pkg.sv
// Shared constants for the write-back stage: datapath widths and LoongArch exception codes.
package stage_wb_pkg;

    localparam int WIDTH      = 32;
    localparam int RADDR      = 5;
    localparam int LOG2TLBNUM = 4;

    localparam logic [5:0] ECODE_INT  = 6'h00;
    localparam logic [5:0] ECODE_PIL  = 6'h01;
    localparam logic [5:0] ECODE_PIS  = 6'h02;
    localparam logic [5:0] ECODE_PIF  = 6'h03;
    localparam logic [5:0] ECODE_PME  = 6'h04;
    localparam logic [5:0] ECODE_PPI  = 6'h07;
    localparam logic [5:0] ECODE_ADEF = 6'h08;
    localparam logic [5:0] ECODE_ALE  = 6'h09;
    localparam logic [5:0] ECODE_TLBR = 6'h3F;

    // Exceptions that carry a faulting virtual address into BADV.
    function automatic logic ecode_has_badv(input logic [5:0] ec);
        return (ec == ECODE_PIL) || (ec == ECODE_PIS) || (ec == ECODE_PIF) ||
               (ec == ECODE_PME) || (ec == ECODE_PPI) || (ec == ECODE_ADEF) ||
               (ec == ECODE_ALE) || (ec == ECODE_TLBR);
    endfunction

endpackage

// File: rtl/stage_wb_load_extend.sv
// Load data alignment and sign/zero extension for byte, half and word loads.
module stage_wb_load_extend
    import stage_wb_pkg::*;
(
    input  logic [WIDTH-1:0] ld_res_i,
    input  logic [1:0]       addr_i,
    input  logic             byte_i,
    input  logic             half_i,
    input  logic             word_i,
    input  logic             signed_i,
    output logic [WIDTH-1:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = ld_res_i[{addr_i, 3'b000} +: 8];
    assign half_sel = addr_i[1] ? ld_res_i[31:16] : ld_res_i[15:0];

    always_comb begin
        data_o = '0;
        if (byte_i) begin
            data_o = {{24{signed_i & byte_sel[7]}}, byte_sel};
        end else if (half_i) begin
            data_o = {{16{signed_i & half_sel[15]}}, half_sel};
        end else if (word_i) begin
            data_o = ld_res_i;
        end
    end

endmodule

// File: rtl/stage_wb.sv
// Write-back stage: latches the MEM payload, drives the GPR/CSR write ports and commits
// exceptions, ertn, TLB ops and refresh redirects as a one-shot flush.
module stage_wb
    import stage_wb_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             pipe_tonext_valid_MEM,
    input  logic             pipe_valid_WB,
    output logic             pipe_ready_go_WB,
    input  logic [WIDTH-1:0] pc_MEM,
    input  logic [WIDTH-1:0] alu_result_MEM,
    input  logic [WIDTH-1:0] ld_res_from_MEM,
    input  logic [WIDTH-1:0] rj_value_MEM,
    input  logic [WIDTH-1:0] rkd_value_MEM,
    input  logic [4:0]       dest_MEM,
    input  logic             byte_we_MEM,
    input  logic             half_we_MEM,
    input  logic             word_we_MEM,
    input  logic             signed_we_MEM,
    input  logic             res_from_mem_MEM,
    input  logic             gpr_we_MEM,
    input  logic             csr_inst_MEM,
    input  logic             csr_we_MEM,
    input  logic             csr_wmask_en_MEM,
    input  logic             ertn_inst_MEM,
    input  logic             has_int_MEM,
    input  logic             needs_refresh_MEM,
    input  logic             exc_from_IF_MEM,
    input  logic             inst_tlbrd_MEM,
    input  logic             inst_tlbwr_MEM,
    input  logic             inst_tlbfill_MEM,
    input  logic [5:0]       ecode_MEM_m,
    input  logic [13:0]      csr_code_MEM,
    input  logic [WIDTH-1:0] csr_rvalue,
    input  logic [WIDTH-1:0] csr_eentry,
    input  logic [WIDTH-1:0] csr_tlbrentry,
    input  logic [WIDTH-1:0] csr_era,
    output logic             rf_we,
    output logic [RADDR-1:0] rf_waddr,
    output logic [WIDTH-1:0] rf_wdata,
    output logic             csr_we,
    output logic [13:0]      csr_num,
    output logic [WIDTH-1:0] csr_wmask,
    output logic [WIDTH-1:0] csr_wvalue,
    output logic             exc_commit,
    output logic [5:0]       exc_ecode,
    output logic [WIDTH-1:0] exc_pc,
    output logic [WIDTH-1:0] exc_badv,
    output logic             exc_badv_we,
    output logic             ertn_commit,
    output logic             tlbrd_we,
    output logic             tlbwr_we,
    output logic             tlbfill_we,
    output logic             br_from_WB,
    output logic [WIDTH-1:0] br_target_WB,
    output logic [WIDTH-1:0] debug_wb_pc,
    output logic [3:0]       debug_wb_rf_we,
    output logic [RADDR-1:0] debug_wb_rf_wnum,
    output logic [WIDTH-1:0] debug_wb_rf_wdata
);

    logic [WIDTH-1:0] pc_q, alu_q, ld_res_q, rj_q, rkd_q;
    logic [4:0]       dest_q;
    logic             byte_q, half_q, word_q, signed_q;
    logic             res_from_mem_q, gpr_we_q, csr_inst_q, csr_we_q, csr_wmask_en_q;
    logic             ertn_q, has_int_q, needs_refresh_q, exc_from_if_q;
    logic             tlbrd_q, tlbwr_q, tlbfill_q;
    logic [5:0]       ecode_q;
    logic [13:0]      csr_code_q;

    logic             flushed_q, flushed_d;
    logic             live, exc, refresh_go;
    logic [5:0]       exc_code;
    logic [WIDTH-1:0] ld_ext, wb_data;

    // Payload carries no reset; pipe_valid_WB qualifies it.
    always_ff @(posedge clk) begin
        if (pipe_tonext_valid_MEM) begin
            pc_q            <= pc_MEM;
            alu_q           <= alu_result_MEM;
            ld_res_q        <= ld_res_from_MEM;
            rj_q            <= rj_value_MEM;
            rkd_q           <= rkd_value_MEM;
            dest_q          <= dest_MEM;
            byte_q          <= byte_we_MEM;
            half_q          <= half_we_MEM;
            word_q          <= word_we_MEM;
            signed_q        <= signed_we_MEM;
            res_from_mem_q  <= res_from_mem_MEM;
            gpr_we_q        <= gpr_we_MEM;
            csr_inst_q      <= csr_inst_MEM;
            csr_we_q        <= csr_we_MEM;
            csr_wmask_en_q  <= csr_wmask_en_MEM;
            ertn_q          <= ertn_inst_MEM;
            has_int_q       <= has_int_MEM;
            needs_refresh_q <= needs_refresh_MEM;
            exc_from_if_q   <= exc_from_IF_MEM;
            tlbrd_q         <= inst_tlbrd_MEM;
            tlbwr_q         <= inst_tlbwr_MEM;
            tlbfill_q       <= inst_tlbfill_MEM;
            ecode_q         <= ecode_MEM_m;
            csr_code_q      <= csr_code_MEM;
        end
    end

    // A new handoff always re-arms the redirect, even when a redirect fires that same cycle.
    always_comb begin
        flushed_d = flushed_q;
        if (pipe_tonext_valid_MEM) begin
            flushed_d = 1'b0;
        end else if (br_from_WB) begin
            flushed_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flushed_q <= 1'b0;
        end else begin
            flushed_q <= flushed_d;
        end
    end

    stage_wb_load_extend u_load_extend (
        .ld_res_i (ld_res_q),
        .addr_i   (alu_q[1:0]),
        .byte_i   (byte_q),
        .half_i   (half_q),
        .word_i   (word_q),
        .signed_i (signed_q),
        .data_o   (ld_ext)
    );

    assign pipe_ready_go_WB = pipe_valid_WB;

    assign live       = pipe_valid_WB && !flushed_q;
    assign exc        = live && (has_int_q || (ecode_q != ECODE_INT));
    assign exc_code   = has_int_q ? ECODE_INT : ecode_q;
    assign refresh_go = live && needs_refresh_q && !exc && !ertn_q;

    assign wb_data = res_from_mem_q ? ld_ext : (csr_inst_q ? csr_rvalue : alu_q);

    assign rf_we    = live && gpr_we_q && !exc && (dest_q != 5'd0);
    assign rf_waddr = pipe_valid_WB ? dest_q : '0;
    assign rf_wdata = pipe_valid_WB ? wb_data : '0;

    assign csr_we     = live && csr_we_q && !exc;
    assign csr_num    = pipe_valid_WB ? csr_code_q : '0;
    assign csr_wmask  = pipe_valid_WB ? (csr_wmask_en_q ? rj_q : '1) : '0;
    assign csr_wvalue = pipe_valid_WB ? rkd_q : '0;

    assign exc_commit  = exc;
    assign exc_ecode   = pipe_valid_WB ? exc_code : '0;
    assign exc_pc      = pipe_valid_WB ? pc_q : '0;
    assign exc_badv    = pipe_valid_WB ? (exc_from_if_q ? pc_q : alu_q) : '0;
    assign exc_badv_we = exc && ecode_has_badv(exc_code);

    assign ertn_commit = live && ertn_q && !exc;
    assign tlbrd_we    = live && !exc && tlbrd_q;
    assign tlbwr_we    = live && !exc && tlbwr_q;
    assign tlbfill_we  = live && !exc && tlbfill_q;

    // Redirect priority: exception, then ertn, then refresh.
    always_comb begin
        br_target_WB = '0;
        if (exc) begin
            br_target_WB = (exc_code == ECODE_TLBR) ? csr_tlbrentry : csr_eentry;
        end else if (ertn_commit) begin
            br_target_WB = csr_era;
        end else if (refresh_go) begin
            br_target_WB = pc_q + WIDTH'(4);
        end
    end

    assign br_from_WB = exc || ertn_commit || refresh_go;

    assign debug_wb_pc       = pipe_valid_WB ? pc_q : '0;
    assign debug_wb_rf_we    = {4{rf_we}};
    assign debug_wb_rf_wnum  = rf_waddr;
    assign debug_wb_rf_wdata = rf_wdata;

endmodule

// File: tb/tb_stage_wb.sv
// Randomized and directed bench for stage_wb against a transaction-level reference model.
module tb_stage_wb;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        pipe_tonext_valid_MEM, pipe_valid_WB, pipe_ready_go_WB;
    logic [31:0] pc_MEM, alu_result_MEM, ld_res_from_MEM, rj_value_MEM, rkd_value_MEM;
    logic [4:0]  dest_MEM;
    logic        byte_we_MEM, half_we_MEM, word_we_MEM, signed_we_MEM;
    logic        res_from_mem_MEM, gpr_we_MEM, csr_inst_MEM, csr_we_MEM, csr_wmask_en_MEM;
    logic        ertn_inst_MEM, has_int_MEM, needs_refresh_MEM, exc_from_IF_MEM;
    logic        inst_tlbrd_MEM, inst_tlbwr_MEM, inst_tlbfill_MEM;
    logic [5:0]  ecode_MEM_m;
    logic [13:0] csr_code_MEM;
    logic [31:0] csr_rvalue, csr_eentry, csr_tlbrentry, csr_era;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        csr_we;
    logic [13:0] csr_num;
    logic [31:0] csr_wmask, csr_wvalue;
    logic        exc_commit;
    logic [5:0]  exc_ecode;
    logic [31:0] exc_pc, exc_badv;
    logic        exc_badv_we, ertn_commit, tlbrd_we, tlbwr_we, tlbfill_we, br_from_WB;
    logic [31:0] br_target_WB, debug_wb_pc, debug_wb_rf_wdata;
    logic [3:0]  debug_wb_rf_we;
    logic [4:0]  debug_wb_rf_wnum;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0] pc, alu, ld, rj, rkd;
        logic [4:0]  dest;
        logic        bw, hw, ww, sw;
        logic        res_from_mem, gpr_we, csr_inst, csr_we, wmask_en;
        logic        ertn, has_int, refresh, exc_if, tlbrd, tlbwr, tlbfill;
        logic [5:0]  ecode;
        logic [13:0] csr_code;
        logic [31:0] csr_rvalue, eentry, tlbrentry, era;
    } txn_t;

    typedef struct packed {
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] rf_wdata;
        logic        csr_we;
        logic [13:0] csr_num;
        logic [31:0] csr_wmask, csr_wvalue;
        logic        exc_commit;
        logic [5:0]  exc_ecode;
        logic [31:0] exc_pc, exc_badv;
        logic        exc_badv_we, ertn, tlbrd, tlbwr, tlbfill, br;
        logic [31:0] br_target, dbg_pc;
        logic [3:0]  dbg_rf_we;
    } out_t;

    stage_wb dut (
        .clk(clk), .reset(reset),
        .pipe_tonext_valid_MEM(pipe_tonext_valid_MEM), .pipe_valid_WB(pipe_valid_WB),
        .pipe_ready_go_WB(pipe_ready_go_WB),
        .pc_MEM(pc_MEM), .alu_result_MEM(alu_result_MEM), .ld_res_from_MEM(ld_res_from_MEM),
        .rj_value_MEM(rj_value_MEM), .rkd_value_MEM(rkd_value_MEM), .dest_MEM(dest_MEM),
        .byte_we_MEM(byte_we_MEM), .half_we_MEM(half_we_MEM), .word_we_MEM(word_we_MEM),
        .signed_we_MEM(signed_we_MEM), .res_from_mem_MEM(res_from_mem_MEM),
        .gpr_we_MEM(gpr_we_MEM), .csr_inst_MEM(csr_inst_MEM), .csr_we_MEM(csr_we_MEM),
        .csr_wmask_en_MEM(csr_wmask_en_MEM), .ertn_inst_MEM(ertn_inst_MEM),
        .has_int_MEM(has_int_MEM), .needs_refresh_MEM(needs_refresh_MEM),
        .exc_from_IF_MEM(exc_from_IF_MEM), .inst_tlbrd_MEM(inst_tlbrd_MEM),
        .inst_tlbwr_MEM(inst_tlbwr_MEM), .inst_tlbfill_MEM(inst_tlbfill_MEM),
        .ecode_MEM_m(ecode_MEM_m), .csr_code_MEM(csr_code_MEM), .csr_rvalue(csr_rvalue),
        .csr_eentry(csr_eentry), .csr_tlbrentry(csr_tlbrentry), .csr_era(csr_era),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .csr_we(csr_we), .csr_num(csr_num), .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue),
        .exc_commit(exc_commit), .exc_ecode(exc_ecode), .exc_pc(exc_pc),
        .exc_badv(exc_badv), .exc_badv_we(exc_badv_we), .ertn_commit(ertn_commit),
        .tlbrd_we(tlbrd_we), .tlbwr_we(tlbwr_we), .tlbfill_we(tlbfill_we),
        .br_from_WB(br_from_WB), .br_target_WB(br_target_WB),
        .debug_wb_pc(debug_wb_pc), .debug_wb_rf_we(debug_wb_rf_we),
        .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
    );

    function automatic out_t dut_vec();
        out_t o;
        o.rf_we = rf_we; o.rf_waddr = rf_waddr; o.rf_wdata = rf_wdata;
        o.csr_we = csr_we; o.csr_num = csr_num; o.csr_wmask = csr_wmask;
        o.csr_wvalue = csr_wvalue; o.exc_commit = exc_commit; o.exc_ecode = exc_ecode;
        o.exc_pc = exc_pc; o.exc_badv = exc_badv; o.exc_badv_we = exc_badv_we;
        o.ertn = ertn_commit; o.tlbrd = tlbrd_we; o.tlbwr = tlbwr_we; o.tlbfill = tlbfill_we;
        o.br = br_from_WB; o.br_target = br_target_WB; o.dbg_pc = debug_wb_pc;
        o.dbg_rf_we = debug_wb_rf_we;
        return o;
    endfunction

    // Reference: what a valid WB instruction commits, given whether its redirect already fired.
    function automatic out_t model(input txn_t t, input logic flushed);
        out_t o;
        logic live, exc;
        logic [5:0] ec;
        logic [31:0] piece, ldv;
        int a;
        o = '0;
        live = !flushed;
        a = int'(t.alu[1:0]);
        ldv = 32'd0;
        if (t.bw) begin
            piece = (t.ld >> (8 * a)) & 32'h0000_00FF;
            ldv = (t.sw && piece[7]) ? (piece | 32'hFFFF_FF00) : piece;
        end else if (t.hw) begin
            piece = (t.ld >> (16 * (a / 2))) & 32'h0000_FFFF;
            ldv = (t.sw && piece[15]) ? (piece | 32'hFFFF_0000) : piece;
        end else if (t.ww) begin
            ldv = t.ld;
        end
        ec  = t.has_int ? 6'h00 : t.ecode;
        exc = live && (t.has_int || t.ecode != 6'h00);
        o.rf_waddr   = t.dest;
        o.rf_wdata   = t.res_from_mem ? ldv : (t.csr_inst ? t.csr_rvalue : t.alu);
        o.rf_we      = live && t.gpr_we && !exc && (t.dest != 5'd0);
        o.csr_we     = live && t.csr_we && !exc;
        o.csr_num    = t.csr_code;
        o.csr_wmask  = t.wmask_en ? t.rj : 32'hFFFF_FFFF;
        o.csr_wvalue = t.rkd;
        o.exc_commit = exc;
        o.exc_ecode  = ec;
        o.exc_pc     = t.pc;
        o.exc_badv   = t.exc_if ? t.pc : t.alu;
        o.exc_badv_we = exc && (ec inside {6'h01, 6'h02, 6'h03, 6'h04, 6'h07, 6'h08, 6'h09, 6'h3F});
        o.ertn    = live && t.ertn && !exc;
        o.tlbrd   = live && !exc && t.tlbrd;
        o.tlbwr   = live && !exc && t.tlbwr;
        o.tlbfill = live && !exc && t.tlbfill;
        if (exc) begin
            o.br = 1'b1;
            o.br_target = (ec == 6'h3F) ? t.tlbrentry : t.eentry;
        end else if (o.ertn) begin
            o.br = 1'b1;
            o.br_target = t.era;
        end else if (live && t.refresh) begin
            o.br = 1'b1;
            o.br_target = t.pc + 32'd4;
        end
        o.dbg_pc    = t.pc;
        o.dbg_rf_we = {4{o.rf_we}};
        return o;
    endfunction

    function automatic txn_t base_txn();
        txn_t t;
        t = '0;
        t.ww = 1'b1;
        t.eentry = 32'h1C00_8000;
        t.tlbrentry = 32'h0000_F000;
        t.era = 32'h1C00_4000;
        return t;
    endfunction

    function automatic txn_t rand_txn();
        txn_t t;
        int w, r;
        t.pc = $urandom() & 32'hFFFF_FFFC;
        t.alu = $urandom(); t.ld = $urandom(); t.rj = $urandom(); t.rkd = $urandom();
        t.dest = 5'($urandom());
        w = $urandom_range(0, 2);
        t.bw = (w == 0); t.hw = (w == 1); t.ww = (w == 2);
        t.sw = 1'($urandom()); t.res_from_mem = 1'($urandom()); t.gpr_we = 1'($urandom());
        t.csr_inst = 1'($urandom()); t.csr_we = 1'($urandom()); t.wmask_en = 1'($urandom());
        t.ertn = ($urandom_range(0, 5) == 0); t.has_int = ($urandom_range(0, 9) == 0);
        t.refresh = ($urandom_range(0, 3) == 0); t.exc_if = 1'($urandom());
        t.tlbrd = 1'($urandom()); t.tlbwr = 1'($urandom()); t.tlbfill = 1'($urandom());
        r = $urandom_range(0, 11);
        case (r)
            6: t.ecode = 6'h01; 7: t.ecode = 6'h08; 8: t.ecode = 6'h09;
            9: t.ecode = 6'h3F; 10: t.ecode = 6'h0B; 11: t.ecode = 6'h07;
            default: t.ecode = 6'h00;
        endcase
        t.csr_code = 14'($urandom());
        t.csr_rvalue = $urandom(); t.eentry = $urandom(); t.tlbrentry = $urandom();
        t.era = $urandom();
        return t;
    endfunction

    task automatic drive_mem(input txn_t t);
        pc_MEM = t.pc; alu_result_MEM = t.alu; ld_res_from_MEM = t.ld;
        rj_value_MEM = t.rj; rkd_value_MEM = t.rkd; dest_MEM = t.dest;
        byte_we_MEM = t.bw; half_we_MEM = t.hw; word_we_MEM = t.ww; signed_we_MEM = t.sw;
        res_from_mem_MEM = t.res_from_mem; gpr_we_MEM = t.gpr_we; csr_inst_MEM = t.csr_inst;
        csr_we_MEM = t.csr_we; csr_wmask_en_MEM = t.wmask_en; ertn_inst_MEM = t.ertn;
        has_int_MEM = t.has_int; needs_refresh_MEM = t.refresh; exc_from_IF_MEM = t.exc_if;
        inst_tlbrd_MEM = t.tlbrd; inst_tlbwr_MEM = t.tlbwr; inst_tlbfill_MEM = t.tlbfill;
        ecode_MEM_m = t.ecode; csr_code_MEM = t.csr_code; csr_rvalue = t.csr_rvalue;
        csr_eentry = t.eentry; csr_tlbrentry = t.tlbrentry; csr_era = t.era;
    endtask

    // Hand t to WB, then hold it valid and settle just after the falling edge.
    task automatic apply(input txn_t t);
        @(negedge clk);
        drive_mem(t);
        pipe_tonext_valid_MEM = 1'b1;
        pipe_valid_WB = 1'b0;
        @(negedge clk);
        pipe_tonext_valid_MEM = 1'b0;
        pipe_valid_WB = 1'b1;
        #1;
    endtask

    task automatic idle();
        @(negedge clk);
        pipe_valid_WB = 1'b0;
        pipe_tonext_valid_MEM = 1'b0;
    endtask

    task automatic test_reset();
        out_t got;
        drive_mem(base_txn());
        reset = 1'b1; pipe_valid_WB = 1'b0; pipe_tonext_valid_MEM = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        got = dut_vec();
        checks++;
        if (got !== '0 || pipe_ready_go_WB !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs got=%h ready=%b exp=0", got, pipe_ready_go_WB);
        end
    endtask

    task automatic test_ld_b();
        txn_t t;
        t = base_txn();
        t.ld = 32'h1234_80FF; t.alu = 32'h0000_1001; t.bw = 1'b1; t.ww = 1'b0; t.sw = 1'b1;
        t.res_from_mem = 1'b1; t.gpr_we = 1'b1; t.dest = 5'd7; t.pc = 32'h1C00_0010;
        apply(t);
        checks++;
        if (rf_wdata !== 32'hFFFF_FF80 || rf_we !== 1'b1 || rf_waddr !== 5'd7) begin
            failures++;
            $display("FAIL ld_b got wdata=%h we=%b addr=%0d exp wdata=ffffff80 we=1 addr=7",
                     rf_wdata, rf_we, rf_waddr);
        end
        checks++;
        if (pipe_ready_go_WB !== 1'b1 || debug_wb_rf_we !== 4'hF || debug_wb_pc !== 32'h1C00_0010) begin
            failures++;
            $display("FAIL ld_b_debug got ready=%b dwe=%h dpc=%h exp 1 f 1c000010",
                     pipe_ready_go_WB, debug_wb_rf_we, debug_wb_pc);
        end
        idle();
    endtask

    task automatic test_ld_hu();
        txn_t t;
        t = base_txn();
        t.ld = 32'h1234_80FF; t.alu = 32'h0000_1002; t.hw = 1'b1; t.ww = 1'b0; t.sw = 1'b0;
        t.res_from_mem = 1'b1; t.gpr_we = 1'b1; t.dest = 5'd9;
        apply(t);
        checks++;
        if (rf_wdata !== 32'h0000_1234 || rf_we !== 1'b1) begin
            failures++;
            $display("FAIL ld_hu got wdata=%h we=%b exp 00001234 1", rf_wdata, rf_we);
        end
        idle();
    endtask

    task automatic test_csrxchg();
        txn_t t;
        t = base_txn();
        t.csr_inst = 1'b1; t.csr_we = 1'b1; t.wmask_en = 1'b1; t.gpr_we = 1'b1; t.dest = 5'd4;
        t.rj = 32'h0000_000F; t.rkd = 32'h0000_00A5; t.csr_rvalue = 32'h0000_0011;
        t.csr_code = 14'h0006;
        apply(t);
        checks++;
        if (csr_we !== 1'b1 || csr_wmask !== 32'hF || csr_wvalue !== 32'hA5 || csr_num !== 14'h6) begin
            failures++;
            $display("FAIL csrxchg_port got we=%b mask=%h val=%h num=%h exp 1 f a5 6",
                     csr_we, csr_wmask, csr_wvalue, csr_num);
        end
        checks++;
        if (rf_wdata !== 32'h0000_0011 || rf_we !== 1'b1) begin
            failures++;
            $display("FAIL csrxchg_rf got wdata=%h we=%b exp 00000011 1", rf_wdata, rf_we);
        end
        idle();
    endtask

    task automatic test_tlbr_exc();
        txn_t t;
        t = base_txn();
        t.ecode = 6'h3F; t.pc = 32'h1C00_0100; t.alu = 32'h8000_0004; t.gpr_we = 1'b1;
        t.dest = 5'd3; t.csr_we = 1'b1; t.tlbwr = 1'b1; t.tlbrentry = 32'h0000_F000;
        apply(t);
        checks++;
        if (exc_commit !== 1'b1 || exc_ecode !== 6'h3F || exc_pc !== 32'h1C00_0100 ||
            exc_badv !== 32'h8000_0004 || exc_badv_we !== 1'b1) begin
            failures++;
            $display("FAIL tlbr_commit got exc=%b ec=%h pc=%h badv=%h bwe=%b exp 1 3f 1c000100 80000004 1",
                     exc_commit, exc_ecode, exc_pc, exc_badv, exc_badv_we);
        end
        checks++;
        if (br_from_WB !== 1'b1 || br_target_WB !== 32'h0000_F000 || rf_we !== 1'b0 ||
            csr_we !== 1'b0 || tlbwr_we !== 1'b0) begin
            failures++;
            $display("FAIL tlbr_redirect got br=%b tgt=%h rfwe=%b csrwe=%b tlbwr=%b exp 1 0000f000 0 0 0",
                     br_from_WB, br_target_WB, rf_we, csr_we, tlbwr_we);
        end
        idle();
    endtask

    task automatic test_refresh_oneshot();
        txn_t t;
        t = base_txn();
        t.refresh = 1'b1; t.tlbwr = 1'b1; t.pc = 32'h1C00_0200;
        apply(t);
        checks++;
        if (br_from_WB !== 1'b1 || br_target_WB !== 32'h1C00_0204 || tlbwr_we !== 1'b1) begin
            failures++;
            $display("FAIL refresh_first got br=%b tgt=%h tlbwr=%b exp 1 1c000204 1",
                     br_from_WB, br_target_WB, tlbwr_we);
        end
        @(negedge clk);
        #1;
        checks++;
        if (br_from_WB !== 1'b0 || tlbwr_we !== 1'b0) begin
            failures++;
            $display("FAIL refresh_second got br=%b tlbwr=%b exp 0 0", br_from_WB, tlbwr_we);
        end
        idle();
    endtask

    task automatic test_store_r0();
        txn_t t;
        t = base_txn();
        t.gpr_we = 1'b1; t.dest = 5'd0; t.alu = 32'hDEAD_BEEF;
        apply(t);
        checks++;
        if (rf_we !== 1'b0 || debug_wb_rf_we !== 4'h0) begin
            failures++;
            $display("FAIL store_r0 got rf_we=%b dbg_we=%h exp 0 0", rf_we, debug_wb_rf_we);
        end
        idle();
    endtask

    task automatic test_handoff_with_redirect();
        txn_t ta, tb;
        ta = base_txn(); ta.refresh = 1'b1; ta.pc = 32'h1C00_0300;
        tb = base_txn(); tb.refresh = 1'b1; tb.pc = 32'h1C00_0400;
        apply(ta);
        checks++;
        if (br_from_WB !== 1'b1 || br_target_WB !== 32'h1C00_0304) begin
            failures++;
            $display("FAIL handoff_first got br=%b tgt=%h exp 1 1c000304", br_from_WB, br_target_WB);
        end
        drive_mem(tb);
        pipe_tonext_valid_MEM = 1'b1;
        @(negedge clk);
        pipe_tonext_valid_MEM = 1'b0;
        #1;
        checks++;
        if (br_from_WB !== 1'b1 || br_target_WB !== 32'h1C00_0404) begin
            failures++;
            $display("FAIL handoff_rearm got br=%b tgt=%h exp 1 1c000404", br_from_WB, br_target_WB);
        end
        idle();
    endtask

    task automatic test_reset_mid();
        txn_t t;
        t = base_txn(); t.refresh = 1'b1; t.pc = 32'h1C00_0500;
        apply(t);
        @(negedge clk);
        #1;
        checks++;
        if (br_from_WB !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_flushed got br=%b exp 0", br_from_WB);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (br_from_WB !== 1'b1 || br_target_WB !== 32'h1C00_0504) begin
            failures++;
            $display("FAIL reset_mid_rearm got br=%b tgt=%h exp 1 1c000504", br_from_WB, br_target_WB);
        end
        idle();
    endtask

    task automatic test_random();
        txn_t t;
        out_t exp1, exp2, got;
        for (int i = 0; i < 60; i++) begin
            t = rand_txn();
            apply(t);
            exp1 = model(t, 1'b0);
            got = dut_vec();
            checks++;
            if (got !== exp1) begin
                failures++;
                $display("FAIL rand_first[%0d] got=%h exp=%h", i, got, exp1);
            end
            @(negedge clk);
            #1;
            exp2 = model(t, exp1.br);
            got = dut_vec();
            checks++;
            if (got !== exp2) begin
                failures++;
                $display("FAIL rand_hold[%0d] got=%h exp=%h", i, got, exp2);
            end
        end
        idle();
    endtask

    initial begin
        reset = 1'b1;
        pipe_valid_WB = 1'b0;
        pipe_tonext_valid_MEM = 1'b0;
        test_reset();
        test_ld_b();
        test_ld_hu();
        test_csrxchg();
        test_tlbr_exc();
        test_refresh_oneshot();
        test_store_r0();
        test_handoff_with_redirect();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
